mic_packet_tx: RTL and testbench

- Downstream of the microphone capture stage, in the mon clock domain.
- Takes 32-bit words of four packed u-law bytes over the valid/retrieved handshake and buffers them in a small FIFO.
- Serialises each word as one sound-in packet onto the monitor transmit path, in a bit slot granted by the monitor transmitter.

---
 rtl/mic_packet_tx_if.sv | 25 ++
 rtl/mic_packet_tx.sv | 183 ++++++++++++++++++
 tb/tb_mic_packet_tx.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mic_packet_tx_if.sv
// Handshake bundle for mic_packet_tx.
//   Capture side : mic_data, mic_data_valid (to DUT), mic_data_retrieved (from DUT)
//   Transmit side: pkt_grant, bit_tick (to DUT); pkt_req, tx_data, tx_active, pkt_done (from DUT)
// slave  = the packetiser itself; master = the capture stage plus monitor transmitter.
interface mic_packet_tx_if;
  logic [31:0] mic_data;
  logic        mic_data_valid;
  logic        mic_data_retrieved;
  logic        pkt_req;
  logic        pkt_grant;
  logic        bit_tick;
  logic        tx_data;
  logic        tx_active;
  logic        pkt_done;

  modport slave (
    input  mic_data, mic_data_valid, pkt_grant, bit_tick,
    output mic_data_retrieved, pkt_req, tx_data, tx_active, pkt_done
  );

  modport master (
    output mic_data, mic_data_valid, pkt_grant, bit_tick,
    input  mic_data_retrieved, pkt_req, tx_data, tx_active, pkt_done
  );
endinterface

// File: rtl/mic_packet_tx.sv
// mic_packet_tx: buffers 32-bit u-law words from the capture stage in a small
// FIFO and serialises each one as a sound-in packet {HDR, word} MSB first
// in a transmit slot granted by the monitor transmitter.
// Ports:
//   clk, rst_n        mon clock, asynchronous active-low reset
//   record_start      pulse, clears the sticky overflow flag
//   record_stop       pulse, flushes the FIFO (a packet in flight completes)
//   bus (slave)       capture handshake + transmit slot/serial interface
//   fifo_level        FIFO occupancy 0..FIFO_DEPTH
//   overflow          sticky, a word was held off while the FIFO was full
// Optional feature: define MIC_TX_PARITY_EN to append an odd-parity bit over
// the 32 data bits after data bit 0 (41-bit packets instead of 40).
module mic_packet_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  HDR        = 8'hC7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            record_start,
  input  logic                            record_stop,
  mic_packet_tx_if.slave                  bus,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);

  localparam int unsigned PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned LW     = PW + 1;
  localparam int unsigned DATA_W = 32;
`ifdef MIC_TX_PARITY_EN
  localparam int unsigned PKT_BITS = 41;
`else
  localparam int unsigned PKT_BITS = 40;
`endif
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, REQ, SEND, DONE} state_t;

  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]       count_q;
  logic                armed_q;
  logic                overflow_q;
  logic                retrieved_q;

  state_t              state_q;
  logic [PKT_BITS-1:0] shreg_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic                pkt_req_q;
  logic                tx_data_q;
  logic                tx_active_q;
  logic                pkt_done_q;

  logic                full;
  logic                pop;
  logic                accept;
  logic                holdoff;
  logic                last_tick;
  logic [DATA_W-1:0]   head;
  logic [PKT_BITS-1:0] load_word;

  // Handshake / FIFO control; pop is evaluated before the full check so a
  // write into a full FIFO is allowed in the cycle its head is granted.
  always_comb begin
    full      = (count_q == LW'(FIFO_DEPTH));
    head      = mem_q[rd_ptr_q];
    pop       = (state_q == REQ) && bus.pkt_grant && !record_stop;
    accept    = bus.mic_data_valid && armed_q && (!full || pop);
    holdoff   = bus.mic_data_valid && armed_q && full && !pop;
    last_tick = (state_q == SEND) && bus.bit_tick &&
                (bit_cnt_q == CNT_W'(PKT_BITS - 1));
`ifdef MIC_TX_PARITY_EN
    // Odd parity: data plus parity bit carries an odd number of ones.
    load_word = {HDR, head, ~(^head)};
`else
    load_word = {HDR, head};
`endif
  end

  // FIFO storage; a word accepted alongside record_stop is dropped.
  always_ff @(posedge clk) begin
    if (accept && !record_stop) begin
      mem_q[wr_ptr_q] <= bus.mic_data;
    end
  end

  // FIFO pointers and occupancy (power-of-two depth wraps naturally).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (record_stop) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + LW'(accept) - LW'(pop);
    end
  end

  // Input side: one take per valid assertion, sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q     <= 1'b1;
      retrieved_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      retrieved_q <= accept;
      if (accept)                   armed_q <= 1'b0;
      else if (!bus.mic_data_valid) armed_q <= 1'b1;
      if (record_start)             overflow_q <= 1'b0;
      else if (holdoff)             overflow_q <= 1'b1;
    end
  end

  // Packet FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      pkt_req_q   <= 1'b0;
      tx_data_q   <= 1'b0;
      tx_active_q <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if ((count_q != '0) && !record_stop) begin
            state_q   <= REQ;
            pkt_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (record_stop) begin
            state_q   <= IDLE;
            pkt_req_q <= 1'b0;
          end else if (bus.pkt_grant) begin
            state_q     <= SEND;
            pkt_req_q   <= 1'b0;
            shreg_q     <= load_word;
            bit_cnt_q   <= '0;
            tx_active_q <= 1'b1;
            tx_data_q   <= HDR[7];
          end
        end
        SEND: begin
          // record_stop is deliberately ignored here: the packet completes.
          if (bus.bit_tick) begin
            shreg_q   <= shreg_q << 1;
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            if (last_tick) begin
              state_q     <= DONE;
              tx_active_q <= 1'b0;
              tx_data_q   <= 1'b0;
              pkt_done_q  <= 1'b1;
            end else begin
              tx_data_q <= shreg_q[PKT_BITS-2];
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mic_data_retrieved = retrieved_q;
  assign bus.pkt_req            = pkt_req_q;
  assign bus.tx_data            = tx_data_q;
  assign bus.tx_active          = tx_active_q;
  assign bus.pkt_done           = pkt_done_q;
  assign fifo_level             = count_q;
  assign overflow               = overflow_q;

endmodule

// File: tb/tb_mic_packet_tx.sv
// Self-checking bench for mic_packet_tx: a transaction-level model (word queue,
// packet bit vector, bit index) predicts every output each cycle, and the
// serialised packets are also compared against hand-written literals.
module tb_mic_packet_tx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 3;
`ifdef MIC_TX_PARITY_EN
  localparam int unsigned PKT_BITS = 41;
`else
  localparam int unsigned PKT_BITS = 40;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          record_start;
  logic          record_stop;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  mic_packet_tx_if bus ();

  mic_packet_tx #(.FIFO_DEPTH(DEPTH), .HDR(8'hC7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .record_start (record_start),
    .record_stop  (record_stop),
    .bus          (bus),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL timeout %s: condition not reached (t=%0t)", nm, $time);
  endtask

  // Packet as the spec defines it: header, word MSB first, optional parity.
  function automatic logic [PKT_BITS-1:0] make_pkt(input logic [31:0] w);
`ifdef MIC_TX_PARITY_EN
    return {8'hC7, w, ~(^w)};
`else
    return {8'hC7, w};
`endif
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum int {M_IDLE, M_REQ, M_SEND, M_DONE} mph_t;
  logic [31:0]         m_q[$];
  bit                  m_armed, m_ovf, m_retr;
  mph_t                m_ph;
  int                  m_idx;
  logic [PKT_BITS-1:0] m_pkt;
  bit                  mf_full, mf_pop, mf_acc, mf_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_armed = 1'b1;
      m_ovf   = 1'b0;
      m_retr  = 1'b0;
      m_ph    = M_IDLE;
      m_idx   = 0;
      m_pkt   = '0;
    end else begin
      mf_full = (m_q.size() == DEPTH);
      mf_pop  = (m_ph == M_REQ) && bus.pkt_grant && !record_stop;
      mf_acc  = bus.mic_data_valid && m_armed && (!mf_full || mf_pop);
      mf_hold = bus.mic_data_valid && m_armed && mf_full && !mf_pop;
      m_retr  = mf_acc;
      if (record_start) m_ovf = 1'b0;
      else if (mf_hold) m_ovf = 1'b1;
      if (mf_acc) m_armed = 1'b0;
      else if (!bus.mic_data_valid) m_armed = 1'b1;
      case (m_ph)
        M_IDLE: if (m_q.size() != 0 && !record_stop) m_ph = M_REQ;
        M_REQ: begin
          if (record_stop) m_ph = M_IDLE;
          else if (bus.pkt_grant) begin
            m_ph  = M_SEND;
            m_pkt = make_pkt(m_q[0]);
            m_idx = 0;
          end
        end
        M_SEND: if (bus.bit_tick) begin
          m_idx++;
          if (m_idx == PKT_BITS) m_ph = M_DONE;
        end
        default: m_ph = M_IDLE;
      endcase
      if (record_stop) m_q.delete();
      else begin
        if (mf_pop) void'(m_q.pop_front());
        if (mf_acc) m_q.push_back(bus.mic_data);
      end
    end
  end

  // ---------------- compare process ----------------
  bit   chk_en = 1'b0;
  logic exp_tx;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_tx = (m_ph == M_SEND) ? m_pkt[PKT_BITS-1-m_idx] : 1'b0;
      chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      chk("overflow",   64'(overflow), 64'(m_ovf));
      chk("retrieved",  64'(bus.mic_data_retrieved), 64'(m_retr));
      chk("pkt_req",    64'(bus.pkt_req), 64'(m_ph == M_REQ));
      chk("tx_active",  64'(bus.tx_active), 64'(m_ph == M_SEND));
      chk("tx_data",    64'(bus.tx_data), 64'(exp_tx));
      chk("pkt_done",   64'(bus.pkt_done), 64'(m_ph == M_DONE));
    end
  end

  // ---------------- monitors ----------------
  int          retr_cnt = 0;
  int          req_cyc  = 0;
  logic [63:0] cap;
  int          cap_n;
  logic [63:0] pkt_log[$];
  int          nbit_log[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap   = '0;
      cap_n = 0;
    end else begin
      if (bus.mic_data_retrieved) retr_cnt++;
      if (bus.pkt_req) req_cyc++;
      if (bus.tx_active && bus.bit_tick) begin
        cap = (cap << 1) | 64'(bus.tx_data);
        cap_n++;
      end
      if (bus.pkt_done) begin
        pkt_log.push_back(cap);
        nbit_log.push_back(cap_n);
        cap   = '0;
        cap_n = 0;
      end
    end
  end

  // ---------------- upstream producer and transmitter ----------------
  logic [31:0] src[$];
  int  src_pct = 100, grant_pct = 50, tick_pct = 50, hold_extra = 0, hold_left = 0;
  bit  grant_en = 1'b1, hold_rand = 1'b0, taken = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.mic_data_valid = 1'b0;
      bus.pkt_grant      = 1'b0;
      bus.bit_tick       = 1'b0;
      taken              = 1'b0;
    end else begin
      if (bus.mic_data_valid) begin
        if (bus.mic_data_retrieved) begin
          taken     = 1'b1;
          hold_left = hold_rand ? int'($urandom_range(0, 2)) : hold_extra;
        end
        if (taken) begin
          if (hold_left == 0) begin
            bus.mic_data_valid = 1'b0;
            taken              = 1'b0;
          end else hold_left--;
        end
      end else if (src.size() != 0 && $urandom_range(0, 99) < src_pct) begin
        bus.mic_data       = src.pop_front();
        bus.mic_data_valid = 1'b1;
      end
      // Stray grants outside a request must be ignored by the DUT.
      if (bus.pkt_req) bus.pkt_grant = grant_en && ($urandom_range(0, 99) < grant_pct);
      else             bus.pkt_grant = ($urandom_range(0, 99) < 5);
      bus.bit_tick = ($urandom_range(0, 99) < tick_pct);
    end
  end

  // ---------------- bounded waits ----------------
  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (!(src.size() == 0 && !bus.mic_data_valid && m_q.size() == 0 && m_ph == M_IDLE)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin timeout(nm); return; end
    end
  endtask

  task automatic wait_retr(input int target, input int budget, input string nm);
    int n = 0;
    while (retr_cnt < target) begin
      @(negedge clk);
      n++;
      if (n > budget) begin timeout(nm); return; end
    end
  endtask

  task automatic wait_bit(input int idx, input int budget, input string nm);
    int n = 0;
    while (!(m_ph == M_SEND && m_idx == idx)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin timeout(nm); return; end
    end
  endtask

  task automatic pulse_stop();
    record_stop = 1'b1;
    @(negedge clk);
    record_stop = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  int r0, p0;
  logic [63:0] e0, e1;

  initial begin
    rst_n              = 1'b0;
    record_start       = 1'b0;
    record_stop        = 1'b0;
    bus.mic_data       = '0;
    bus.mic_data_valid = 1'b0;
    bus.pkt_grant      = 1'b0;
    bus.bit_tick       = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_fifo_level", 64'(fifo_level), 64'd0);
    chk("rst_overflow",   64'(overflow), 64'd0);
    chk("rst_pkt_req",    64'(bus.pkt_req), 64'd0);
    chk("rst_tx_active",  64'(bus.tx_active), 64'd0);
    chk("rst_tx_data",    64'(bus.tx_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single word.
    r0 = retr_cnt; p0 = pkt_log.size();
    src.push_back(32'h5A5AA5A5);
    wait_idle(2000, "single");
    repeat (3) @(negedge clk);
`ifdef MIC_TX_PARITY_EN
    e0 = 64'({40'hC75A5AA5A5, 1'b1});
`else
    e0 = 64'h00_0000_C75A5AA5A5;
`endif
    chk("single_retrieves", 64'(retr_cnt - r0), 64'd1);
    chk("single_npkts", 64'(pkt_log.size() - p0), 64'd1);
    if (pkt_log.size() > p0) begin
      chk("single_bits",  pkt_log[p0], e0);
      chk("single_nbits", 64'(nbit_log[p0]), 64'(PKT_BITS));
    end
    chk("single_level", 64'(fifo_level), 64'd0);

    // Valid held three cycles after retrieve, then an all-ones word.
    hold_extra = 3;
    r0 = retr_cnt; p0 = pkt_log.size();
    src.push_back(32'h0F0F1234);
    src.push_back(32'hFFFFFFFF);
    wait_idle(4000, "held");
    repeat (3) @(negedge clk);
    hold_extra = 0;
`ifdef MIC_TX_PARITY_EN
    e0 = 64'({40'hC70F0F1234, 1'b0});
    e1 = 64'({40'hC7FFFFFFFF, 1'b1});
`else
    e0 = 64'h00_0000_C70F0F1234;
    e1 = 64'h00_0000_C7FFFFFFFF;
`endif
    chk("held_retrieves", 64'(retr_cnt - r0), 64'd2);
    chk("held_npkts", 64'(pkt_log.size() - p0), 64'd2);
    if (pkt_log.size() > p0 + 1) begin
      chk("held_pkt0", pkt_log[p0], e0);
      chk("held_pkt1", pkt_log[p0+1], e1);
    end

    // Overflow: five words with no grant.
    grant_en = 1'b0;
    r0 = retr_cnt;
    for (int i = 0; i < 5; i++) src.push_back($urandom);
    wait_retr(r0 + 4, 500, "ovf_fill");
    repeat (10) @(negedge clk);
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_retrieves", 64'(retr_cnt - r0), 64'd4);
    grant_en = 1'b1;
    wait_retr(r0 + 5, 2000, "ovf_fifth");
    chk("ovf_sticky", 64'(overflow), 64'd1);
    record_start = 1'b1;
    @(negedge clk);
    record_start = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);
    wait_idle(8000, "ovf_drain");

    // record_stop at tick 10 with two words queued behind the packet.
    grant_en = 1'b0;
    p0 = pkt_log.size();
    src.push_back(32'hDEADBEEF);
    src.push_back(32'h11111111);
    src.push_back(32'h22222222);
    wait_retr(retr_cnt + 3, 500, "stop_fill");
    grant_en = 1'b1;
    wait_bit(0, 500, "stop_grant");
    grant_en = 1'b0;
    wait_bit(10, 500, "stop_tick10");
    chk("stop_level_before", 64'(fifo_level), 64'd2);
    pulse_stop();
    chk("stop_level_after", 64'(fifo_level), 64'd0);
    grant_en = 1'b1;
    req_cyc = 0;
    wait_idle(2000, "stop_finish");
    repeat (30) @(negedge clk);
`ifdef MIC_TX_PARITY_EN
    e0 = 64'({40'hC7DEADBEEF, 1'b1});
`else
    e0 = 64'h00_0000_C7DEADBEEF;
`endif
    chk("stop_npkts", 64'(pkt_log.size() - p0), 64'd1);
    if (pkt_log.size() > p0) begin
      chk("stop_bits",  pkt_log[p0], e0);
      chk("stop_nbits", 64'(nbit_log[p0]), 64'(PKT_BITS));
    end
    chk("stop_no_req", 64'(req_cyc), 64'd0);

    // Asynchronous reset at tick 20.
    src.push_back(32'hCAFEF00D);
    src.push_back(32'h0BADBEEF);
    wait_bit(20, 2000, "rst_tick20");
    #2;
    rst_n = 1'b0;
    src.delete();
    #1;
    chk("arst_tx_data",   64'(bus.tx_data), 64'd0);
    chk("arst_tx_active", 64'(bus.tx_active), 64'd0);
    chk("arst_pkt_req",   64'(bus.pkt_req), 64'd0);
    chk("arst_level",     64'(fifo_level), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_level_release", 64'(fifo_level), 64'd0);

`ifdef MIC_TX_PARITY_EN
    // Parity bit for a single one and for all zeros.
    p0 = pkt_log.size();
    src.push_back(32'h00000001);
    src.push_back(32'h00000000);
    wait_idle(4000, "parity");
    repeat (3) @(negedge clk);
    chk("par_npkts", 64'(pkt_log.size() - p0), 64'd2);
    if (pkt_log.size() > p0 + 1) begin
      chk("par_one",  pkt_log[p0],   64'h0000_018E_0000_0002);
      chk("par_zero", pkt_log[p0+1], 64'h0000_018E_0000_0001);
      chk("par_nbits", 64'(nbit_log[p0]), 64'd41);
    end
`endif

    // Randomised traffic.
    hold_rand = 1'b1;
    src_pct   = 40;
    grant_pct = 30;
    tick_pct  = 60;
    r0 = retr_cnt; p0 = pkt_log.size();
    for (int i = 0; i < 25; i++) src.push_back($urandom);
    wait_idle(20000, "random");
    repeat (3) @(negedge clk);
    chk("rand_retrieves", 64'(retr_cnt - r0), 64'd25);
    chk("rand_npkts", 64'(pkt_log.size() - p0), 64'd25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

endmodule
